vvp_shacc: RTL and testbench

//  Bit-serial shift-accumulator directly downstream of the vvp reduction tree.
//  vvp emits one signed partial sum per cycle, one sum per (weight-plane, data-plane) pair.

---
 rtl/vvp_shacc.sv | 131 +++++++++++++
 tb/tb_vvp_shacc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vvp_shacc.sv
// Bit-serial shift-accumulator behind the vvp reduction tree.
// Folds MSB-first plane partial sums into one saturated dot product.
module vvp_shacc #(
    parameter int N    = 64,
    parameter int IW   = $clog2(N) + 2,
    parameter int OW   = 32,
    parameter int PMAX = 16,
    parameter int CW   = $clog2(PMAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] in_s,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic                 in_neg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic        [CW-1:0] out_planes,
    output logic                 out_sat,
    output logic                 proto_err
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic signed [OW+1:0] MAXV = {3'b000, {(OW-1){1'b1}}};
    localparam logic signed [OW+1:0] MINV = {3'b111, {(OW-1){1'b0}}};
    localparam logic [CW-1:0] PMAX_C = CW'(PMAX);

    state_t state;
    logic signed [OW-1:0] acc;
    logic [CW-1:0] cnt;
    logic sat;

    logic accept, drop, upd, n_err, n_sat;
    logic signed [OW-1:0] n_acc;
    logic [CW-1:0] n_cnt;
    logic signed [OW+1:0] s_ext, t, t_c, sh, sh_c, sum, sum_c;
    logic t_ovf, sh_ovf, sum_ovf;

    function automatic logic signed [OW+1:0] clamp(input logic signed [OW+1:0] v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic logic ovf(input logic signed [OW+1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign drop     = (state == IDLE) || (cnt == PMAX_C);

    // Shift is clamped before the add so a saturated acc stays pinned.
    always_comb begin
        s_ext   = {{(OW+2-IW){in_s[IW-1]}}, in_s};
        t       = in_neg ? -s_ext : s_ext;
        t_c     = clamp(t);
        t_ovf   = ovf(t);
        sh      = {acc[OW-1], acc, 1'b0};
        sh_c    = clamp(sh);
        sh_ovf  = ovf(sh);
        sum     = sh_c + t;
        sum_c   = clamp(sum);
        sum_ovf = ovf(sum);
    end

    always_comb begin
        upd   = 1'b0;
        n_err = 1'b0;
        n_acc = acc;
        n_cnt = cnt;
        n_sat = sat;
        if (accept) begin
            unique case (1'b1)
                in_first: begin
                    upd   = 1'b1;
                    n_err = (state == ACC);
                    n_acc = t_c[OW-1:0];
                    n_cnt = CW'(1);
                    n_sat = t_ovf;
                end
                !in_first && drop: begin
                    n_err = 1'b1;
                end
                !in_first && !drop: begin
                    upd   = 1'b1;
                    n_acc = sum_c[OW-1:0];
                    n_cnt = cnt + 1'b1;
                    n_sat = sat | sh_ovf | sum_ovf;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_planes <= '0;
            out_sat    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            proto_err <= n_err;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (upd) begin
                acc <= n_acc;
                cnt <= n_cnt;
                sat <= n_sat;
                if (in_last) begin
                    out_data   <= n_acc;
                    out_planes <= n_cnt;
                    out_sat    <= n_sat;
                    out_valid  <= 1'b1;
                    state      <= IDLE;
                end else begin
                    state <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_vvp_shacc.sv
// Directed self-checking bench for vvp_shacc.
// Instance u0 uses OW=32, u8 uses OW=8 for saturation cases.
module tb_vvp_shacc;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_first, in_last, in_neg;
    logic signed [7:0] in_s;
    logic out_ready;
    logic in_ready, out_valid, out_sat, proto_err;
    logic signed [31:0] out_data;
    logic [4:0] out_planes;
    logic r8, v8, s8, e8;
    logic signed [7:0] d8;
    logic [4:0] p8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vvp_shacc #(.N(64), .OW(32), .PMAX(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_first(in_first), .in_last(in_last), .in_neg(in_neg),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_planes(out_planes), .out_sat(out_sat), .proto_err(proto_err)
    );

    vvp_shacc #(.N(64), .OW(8), .PMAX(16)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8),
        .in_s(in_s), .in_first(in_first), .in_last(in_last), .in_neg(in_neg),
        .out_valid(v8), .out_ready(1'b1), .out_data(d8),
        .out_planes(p8), .out_sat(s8), .proto_err(e8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic beat(input int s, input logic f, input logic l, input logic n);
        in_s     = s[7:0];
        in_first = f;
        in_last  = l;
        in_neg   = n;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        in_s = '0; in_first = 1'b0; in_last = 1'b0; in_neg = 1'b0;
        idle(); idle();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_planes", out_planes, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;

        // 1: unsigned 3*2+5
        beat(3, 1, 0, 0);
        chk("t1_nvalid", out_valid, 0);
        beat(5, 0, 1, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 11);
        chk("t1_planes", out_planes, 2);
        chk("t1_sat", out_sat, 0);
        chk("t1_err", proto_err, 0);
        idle();
        chk("t1_clear", out_valid, 0);

        // 2: signed -4*2-2, then single plane -(-7)
        beat(4, 1, 0, 1);
        beat(-2, 0, 1, 0);
        chk("t2_data", out_data, -10);
        beat(-7, 1, 1, 1);
        chk("t2b_valid", out_valid, 1);
        chk("t2b_data", out_data, 7);
        chk("t2b_planes", out_planes, 1);
        idle();

        // 3: backpressure
        out_ready = 1'b0;
        beat(6, 1, 1, 0);
        chk("t3_data0", out_data, 6);
        in_s = 8'sd9; in_first = 1'b1; in_last = 1'b1; in_neg = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_ready", in_ready, 0);
            chk("t3_hold_v", out_valid, 1);
            chk("t3_hold_d", out_data, 6);
            idle();
        end
        out_ready = 1'b1;
        idle();
        in_valid = 1'b0;
        chk("t3_xfer_v", out_valid, 1);
        chk("t3_xfer_d", out_data, 9);
        for (int k = 1; k <= 3; k++) begin
            beat(k, 1, 1, 0);
            chk("t3_b2b_v", out_valid, 1);
            chk("t3_b2b_d", out_data, k);
        end
        idle();
        chk("t3_drain", out_valid, 0);

        // 4: saturation on OW=8 instance
        beat(64, 1, 0, 0);
        beat(64, 0, 0, 0);
        beat(64, 0, 1, 0);
        chk("t4_pos_v", v8, 1);
        chk("t4_pos_d", d8, 127);
        chk("t4_pos_s", s8, 1);
        chk("t4_wide_d", out_data, 448);
        chk("t4_wide_s", out_sat, 0);
        beat(64, 1, 0, 1);
        beat(64, 0, 1, 1);
        chk("t4_neg_d", d8, -128);
        chk("t4_neg_s", s8, 1);
        chk("t4_neg_p", p8, 2);
        idle();

        // 5: framing
        beat(1, 0, 0, 0);
        chk("t5_idle_err", proto_err, 1);
        chk("t5_idle_v", out_valid, 0);
        idle();
        chk("t5_err_pulse", proto_err, 0);
        beat(2, 1, 0, 0);
        beat(9, 1, 1, 0);
        chk("t5_refirst_err", proto_err, 1);
        chk("t5_refirst_d", out_data, 9);
        chk("t5_refirst_p", out_planes, 1);
        idle();
        beat(1, 1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            beat(1, 0, 0, 0);
            chk("t5_fill_err", proto_err, 0);
        end
        beat(1, 0, 0, 0);
        chk("t5_pmax_err", proto_err, 1);
        beat(0, 0, 1, 0);
        chk("t5_pmax_last_err", proto_err, 1);
        chk("t5_pmax_last_v", out_valid, 0);
        idle();

        // 6: reset mid-product
        beat(3, 1, 0, 0);
        beat(1, 0, 0, 0);
        rst = 1'b1;
        idle();
        chk("t6_rst_v", out_valid, 0);
        chk("t6_rst_d", out_data, 0);
        chk("t6_rst_p", out_planes, 0);
        chk("t6_rst_s", out_sat, 0);
        chk("t6_rst_e", proto_err, 0);
        rst = 1'b0;
        beat(5, 0, 1, 0);
        chk("t6_err", proto_err, 1);
        chk("t6_v", out_valid, 0);
        idle();
        chk("t6_v2", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
